// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: alu_op classes,
// funct codes and the 4-bit ALU select values.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_DIV  = 4'b1000;
  localparam logic [3:0] SEL_DIVU = 4'b1001;
  localparam logic [3:0] SEL_SLL  = 4'b1010;
  localparam logic [3:0] SEL_SRL  = 4'b1011;
  localparam logic [3:0] SEL_NOR  = 4'b1100;

  localparam logic [3:0] SEL_DEFAULT = SEL_ADD;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder: inst_f -> {select, illegal}.
// Divide codes are legal only when ALU_CTRL_DIV_EN is defined.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] inst_f_i,
  output logic [3:0] sel_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = SEL_DEFAULT;
    illegal_o = 1'b0;
    case (inst_f_i)
      F_ADD,
      F_ADDU: sel_o = SEL_ADD;
      F_SUB,
      F_SUBU: sel_o = SEL_SUB;
      F_AND:  sel_o = SEL_AND;
      F_OR:   sel_o = SEL_OR;
      F_XOR:  sel_o = SEL_XOR;
      F_NOR:  sel_o = SEL_NOR;
      F_SLT:  sel_o = SEL_SLT;
      F_SLL:  sel_o = SEL_SLL;
      F_SRL:  sel_o = SEL_SRL;
`ifdef ALU_CTRL_DIV_EN
      F_DIV:  sel_o = SEL_DIV;
      F_DIVU: sel_o = SEL_DIVU;
`endif
      default: begin
        sel_o     = SEL_DEFAULT;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// Registered ALU control decoder: muxes alu_op class, funct decode and
// immediate flags into the ALU select. Optional macro: ALU_CTRL_DIV_EN.
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       andi,
  input  logic       ori,
  input  logic       addi,
  input  logic       subi,
  input  logic [5:0] inst_f,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control_signal,
  output logic       illegal
);

  logic [3:0] f_sel;
  logic       f_ill;
  logic [3:0] sel_d, sel_q;
  logic       ill_d, ill_q;

  alu_funct_decode u_funct (
    .inst_f_i  (inst_f),
    .sel_o     (f_sel),
    .illegal_o (f_ill)
  );

  // Funct and flags only feed the mux leg that owns them, so X on the
  // unused inputs never propagates.
  always_comb begin
    sel_d = SEL_DEFAULT;
    ill_d = 1'b0;
    case (alu_op)
      ALUOP_MEM: sel_d = SEL_ADD;
      ALUOP_BEQ: sel_d = SEL_SUB;
      ALUOP_RTYPE: begin
        sel_d = f_sel;
        ill_d = f_ill;
      end
      ALUOP_IMM: begin
        if (andi)      sel_d = SEL_AND;
        else if (ori)  sel_d = SEL_OR;
        else if (addi) sel_d = SEL_ADD;
        else if (subi) sel_d = SEL_SUB;
        else begin
          sel_d = SEL_DEFAULT;
          ill_d = 1'b1;
        end
      end
      default: begin
        sel_d = SEL_DEFAULT;
        ill_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= SEL_DEFAULT;
      ill_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ill_q <= ill_d;
    end
  end

  assign alu_control_signal = sel_q;
  assign illegal            = ill_q;

endmodule

// File: tb/tb_alu_control.sv
// Randomized self-checking bench for alu_control against a table-driven
// reference model of the decode rules.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       andi, ori, addi, subi;
  logic [5:0] inst_f;
  logic [1:0] alu_op;
  logic [3:0] alu_control_signal;
  logic       illegal;

  int checks = 0;
  int failures = 0;

  logic [3:0] ftab [int];
  logic [4:0] prev_exp;

  alu_control dut (
    .clk                (clk),
    .reset              (reset),
    .andi               (andi),
    .ori                (ori),
    .addi               (addi),
    .subi               (subi),
    .inst_f             (inst_f),
    .alu_op             (alu_op),
    .alu_control_signal (alu_control_signal),
    .illegal            (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got,
                     input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got sel=%b ill=%b, expected sel=%b ill=%b",
               tag, got[4:1], got[0], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [4:0] model(input bit rst, input logic [1:0] op,
                                       input logic [5:0] f,
                                       input logic a, input logic o,
                                       input logic ad, input logic s);
    if (rst) return {4'd2, 1'b0};
    if (op == 2'd0) return {4'd2, 1'b0};
    if (op == 2'd1) return {4'd6, 1'b0};
    if (op == 2'd2) begin
      if (ftab.exists(int'(f))) return {ftab[int'(f)], 1'b0};
      return {4'd2, 1'b1};
    end
    if (a)  return {4'd0, 1'b0};
    if (o)  return {4'd1, 1'b0};
    if (ad) return {4'd2, 1'b0};
    if (s)  return {4'd6, 1'b0};
    return {4'd2, 1'b1};
  endfunction

  function automatic logic [4:0] outs();
    return {alu_control_signal, illegal};
  endfunction

  // Apply inputs mid-cycle, confirm the output still holds the previous
  // decode, then check the new decode one edge later.
  task automatic step(input string tag, input bit rst, input logic [1:0] op,
                      input logic [5:0] f, input logic [3:0] flags);
    logic [4:0] e;
    reset = rst;
    alu_op = op;
    inst_f = f;
    {andi, ori, addi, subi} = flags;
    #1;
    chk({tag, "_hold"}, outs(), prev_exp);
    e = model(rst, op, f, flags[3], flags[2], flags[1], flags[0]);
    @(posedge clk);
    #1;
    chk(tag, outs(), e);
    prev_exp = e;
  endtask

  initial begin
    logic [5:0] known [13];
    logic [5:0] f;
    logic [4:0] e;
    ftab[32] = 4'd2;  ftab[33] = 4'd2;
    ftab[34] = 4'd6;  ftab[35] = 4'd6;
    ftab[36] = 4'd0;  ftab[37] = 4'd1;
    ftab[38] = 4'd3;  ftab[39] = 4'd12;
    ftab[42] = 4'd7;  ftab[0]  = 4'd10;
    ftab[2]  = 4'd11;
`ifdef ALU_CTRL_DIV_EN
    ftab[26] = 4'd8;  ftab[27] = 4'd9;
`endif
    known = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38,
              6'd39, 6'd42, 6'd0, 6'd2, 6'd26, 6'd27};

    reset = 1'b1;
    alu_op = 2'($urandom);
    inst_f = 6'($urandom);
    {andi, ori, addi, subi} = 4'($urandom);
    @(posedge clk);
    #1;
    chk("reset1", outs(), {4'd2, 1'b0});
    alu_op = 2'd2;
    inst_f = 6'd34;
    @(posedge clk);
    #1;
    chk("reset2", outs(), {4'd2, 1'b0});
    prev_exp = {4'd2, 1'b0};

    step("r_add", 0, 2'd2, 6'b100000, 4'b0000);
    step("r_slt", 0, 2'd2, 6'b101010, 4'b1111);
    step("r_nor", 0, 2'd2, 6'b100111, 4'b0000);
    step("r_div", 0, 2'd2, 6'b011010, 4'b0000);
    step("r_divu", 0, 2'd2, 6'b011011, 4'b0000);
    step("r_bad", 0, 2'd2, 6'b111111, 4'b0000);

    step("lw_x", 0, 2'd0, 6'bxxxxxx, 4'bxxxx);
    checks++;
    if ($isunknown(outs())) begin
      failures++;
      $display("FAIL lw_xprop: got %b, expected no X", outs());
    end
    step("beq_x", 0, 2'd1, 6'bxxxxxx, 4'bxxxx);
    checks++;
    if ($isunknown(outs())) begin
      failures++;
      $display("FAIL beq_xprop: got %b, expected no X", outs());
    end

    step("imm_ori_addi", 0, 2'd3, 6'bxxxxxx, 4'b0110);
    step("imm_all", 0, 2'd3, 6'bxxxxxx, 4'b1111);
    step("imm_subi", 0, 2'd3, 6'bxxxxxx, 4'b0001);
    step("imm_none", 0, 2'd3, 6'bxxxxxx, 4'b0000);

    step("r_sub", 0, 2'd2, 6'b100010, 4'b0000);
    step("rst_mid", 1, 2'd2, 6'b100010, 4'b0000);
    step("post_rst", 0, 2'd2, 6'b100010, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(1, 0) == 1) ? known[$urandom_range(12, 0)]
                                      : 6'($urandom);
      step("rand", $urandom_range(19, 0) == 0, 2'($urandom), f,
           4'($urandom));
    end

    e = model(0, 2'd2, 6'd26, 0, 0, 0, 0);
    step("div_final", 0, 2'd2, 6'd26, 4'b0000);
    checks++;
`ifdef ALU_CTRL_DIV_EN
    if (e !== {4'd8, 1'b0}) begin
`else
    if (e !== {4'd2, 1'b1}) begin
`endif
      failures++;
      $display("FAIL div_model: got %b", e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
